// File: rtl/ad7606_emu.sv
// Cycle-level responder model of the AD7606 8-channel parallel-read ADC.
// Optional feature: define AD7606_EMU_OS_EN to scale busy time by the oversampling ratio.
module ad7606_emu #(
  parameter int CONV_CYCLES = 200,
  parameter int NCH         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [16*NCH-1:0] ch_data,
  input  logic              convst,
  input  logic              ad_rst,
  input  logic [2:0]        ad_os,
  input  logic              ad_cs,
  input  logic              ad_rd,
  output logic              ad_busy,
  output logic              firstdata,
  output logic [15:0]       ad_data_out,
  output logic              ad_data_oe,
  output logic              convst_ignored,
  output logic [15:0]       conv_count
);

`ifdef AD7606_EMU_OS_EN
  localparam int CW = 19;
`else
  localparam int CW = 12;
`endif

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] conv_time;
  logic          convst_q, rd_q, oe;
  logic [2:0]    ptr;
  logic [15:0]   bank [NCH];
  logic          convst_rise, rd_rise, conv_done;

  assign convst_rise = convst & ~convst_q;
  assign rd_rise     = ad_rd & ~rd_q;
  assign conv_done   = (state == CONV) && (cnt == '0);

`ifdef AD7606_EMU_OS_EN
  // ad_os=7 is not a legal ratio on the real part; fall back to no oversampling
  always_comb begin
    conv_time = CW'(CONV_CYCLES);
    if (ad_os != 3'd7) conv_time = CW'(CONV_CYCLES) << ad_os;
  end
`else
  logic unused_os;
  assign unused_os = ^ad_os;
  assign conv_time = CW'(CONV_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ad_rst) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (convst_rise) state_nxt = CONV;
        CONV:    if (cnt == '0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ad_busy     = (state == CONV);
    ad_data_oe  = oe;
    ad_data_out = oe ? bank[ptr] : 16'h0000;
    firstdata   = oe & (ptr == 3'd0);
  end

  // rd_q resets high so an idle-high strobe is not mistaken for a rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      convst_q       <= 1'b0;
      rd_q           <= 1'b1;
      oe             <= 1'b0;
      ptr            <= 3'd0;
      cnt            <= '0;
      conv_count     <= 16'h0000;
      convst_ignored <= 1'b0;
      for (int i = 0; i < NCH; i++) bank[i] <= 16'h0000;
    end else begin
      convst_q       <= convst;
      rd_q           <= ad_rd;
      oe             <= ~ad_cs & ~ad_rd;
      convst_ignored <= convst_rise & (ad_rst | (state == CONV));
      if (ad_rst) begin
        cnt <= '0;
        ptr <= 3'd0;
        for (int i = 0; i < NCH; i++) bank[i] <= 16'h0000;
      end else begin
        // end of conversion takes precedence over a same-cycle read advance
        if (conv_done) begin
          for (int i = 0; i < NCH; i++) bank[i] <= ch_data[16*i +: 16];
          ptr        <= 3'd0;
          conv_count <= conv_count + 16'd1;
        end else if (rd_rise & ~ad_cs) begin
          ptr <= ptr + 3'd1;
        end
        if ((state == IDLE) && convst_rise) cnt <= conv_time - CW'(1);
        else if ((state == CONV) && (cnt != '0)) cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ad7606_emu.sv
// Bench for ad7606_emu: conversion timing, read sequencing, abort and wrap behaviour.
// Read words are checked through a scoreboard fed by the read task.
module tb_ad7606_emu;

`ifdef AD7606_EMU_OS_EN
  localparam int CC = 10;
`else
  localparam int CC = 200;
`endif

  logic         clk = 1'b0;
  logic         rst, convst, ad_rst, ad_cs, ad_rd;
  logic [2:0]   ad_os;
  logic [127:0] ch_data;
  logic         ad_busy, firstdata, ad_data_oe, convst_ignored;
  logic [15:0]  ad_data_out, conv_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic        first;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        cs;
    logic [15:0] data;
    logic        first;
  } rd_vec_t;
  rd_vec_t vec[12];

  always #5 clk = ~clk;

  ad7606_emu #(.CONV_CYCLES(CC), .NCH(8)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .convst(convst), .ad_rst(ad_rst),
    .ad_os(ad_os), .ad_cs(ad_cs), .ad_rd(ad_rd), .ad_busy(ad_busy),
    .firstdata(firstdata), .ad_data_out(ad_data_out), .ad_data_oe(ad_data_oe),
    .convst_ignored(convst_ignored), .conv_count(conv_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compare the driven word on the first cycle the bus is enabled
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (ad_data_oe && !oe_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got %0h expected no read", ad_data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", {16'h0, ad_data_out}, {16'h0, e.data});
        check("rd_firstdata", {31'h0, firstdata}, {31'h0, e.first});
      end
    end
    oe_prev = ad_data_oe;
  end

  task automatic rd_strobe(input logic cs, input logic [15:0] exp, input logic fd);
    if (!cs) sb.push_back('{exp, fd});
    ad_cs = cs;
    ad_rd = 1'b0;
    tick;
    tick;
    if (cs) check("oe_with_cs_high", {31'h0, ad_data_oe}, 32'h0);
    ad_rd = 1'b1;
    tick;
    ad_cs = 1'b1;
    tick;
  endtask

  // Starts a conversion, optionally re-pulses convst, returns measured busy length
  task automatic run_conv(input int repulse_at, output int busy_len, output int ign);
    check("busy_before_edge", {31'h0, ad_busy}, 32'h0);
    convst = 1'b1;
    tick;
    check("busy_rise_latency", {31'h0, ad_busy}, 32'h1);
    busy_len = 0;
    ign = 0;
    while (ad_busy && busy_len < 5000) begin
      busy_len++;
      convst = (busy_len == repulse_at);
      tick;
      ign += int'(convst_ignored);
    end
    convst = 1'b0;
  endtask

  int blen, ign;
  logic [15:0] cnt0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; convst = 1'b0; ad_rst = 1'b0; ad_cs = 1'b1; ad_rd = 1'b1;
    ad_os = 3'd0; ch_data = '0;

    // Reset state
    repeat (3) tick;
    check("rst_busy", {31'h0, ad_busy}, 32'h0);
    check("rst_firstdata", {31'h0, firstdata}, 32'h0);
    check("rst_data", {16'h0, ad_data_out}, 32'h0);
    check("rst_oe", {31'h0, ad_data_oe}, 32'h0);
    check("rst_ignored", {31'h0, convst_ignored}, 32'h0);
    check("rst_count", {16'h0, conv_count}, 32'h0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < 8; i++) rd_strobe(1'b0, 16'h0000, i == 0);

    // Basic conversion and readback of 1..8
    for (int i = 0; i < 8; i++) ch_data[16*i +: 16] = 16'(i + 1);
    run_conv(0, blen, ign);
    check("conv_busy_len", blen, CC);
    check("conv_ignored", ign, 0);
    check("conv_count_1", {16'h0, conv_count}, 32'd1);
    for (int i = 0; i < 8; i++) rd_strobe(1'b0, 16'(i + 1), i == 0);

    // convst re-pulsed during busy
    run_conv(CC / 4, blen, ign);
    check("repulse_busy_len", blen, CC);
    check("repulse_ignored", ign, 1);
    check("repulse_count", {16'h0, conv_count}, 32'd2);

    // Abort with ad_rst after three reads
    for (int i = 0; i < 3; i++) rd_strobe(1'b0, 16'(i + 1), i == 0);
    cnt0 = conv_count;
    convst = 1'b1;
    tick;
    convst = 1'b0;
    repeat (CC / 4) tick;
    check("abort_busy_pre", {31'h0, ad_busy}, 32'h1);
    ad_rst = 1'b1;
    convst = 1'b1;
    tick;
    check("abort_busy", {31'h0, ad_busy}, 32'h0);
    check("abort_rst_ignored", {31'h0, convst_ignored}, 32'h1);
    convst = 1'b0;
    tick;
    ad_rst = 1'b0;
    repeat (CC + 5) tick;
    check("abort_stays_idle", {31'h0, ad_busy}, 32'h0);
    check("abort_count_held", {16'h0, conv_count}, {16'h0, cnt0});
    rd_strobe(1'b0, 16'h0000, 1'b1);

    // Pointer wrap and cs-high strobes, table driven
    for (int i = 0; i < 8; i++) ch_data[16*i +: 16] = 16'hA5A0 + 16'(i + 1);
    run_conv(0, blen, ign);
    check("wrap_busy_len", blen, CC);
    for (int i = 0; i < 10; i++) vec[i] = '{1'b0, 16'hA5A0 + 16'((i % 8) + 1), (i % 8) == 0};
    vec[10] = '{1'b1, 16'h0000, 1'b0};
    vec[11] = '{1'b1, 16'h0000, 1'b0};
    // two cs-high strobes after word 1 and word 5 must not advance the pointer
    rd_strobe(vec[0].cs, vec[0].data, vec[0].first);
    rd_strobe(vec[10].cs, vec[10].data, vec[10].first);
    for (int i = 1; i < 10; i++) begin
      if (i == 5) rd_strobe(vec[11].cs, vec[11].data, vec[11].first);
      rd_strobe(vec[i].cs, vec[i].data, vec[i].first);
    end

`ifdef AD7606_EMU_OS_EN
    ad_os = 3'd3;
    run_conv(0, blen, ign);
    check("os3_busy_len", blen, CC * 8);
    ad_os = 3'd7;
    run_conv(0, blen, ign);
    check("os7_busy_len", blen, CC);
    ad_os = 3'd0;
`endif

    repeat (4) tick;
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
